// File: rtl/note_recorder.sv
`default_nettype none
// ============================================================================
// Module   : note_recorder
// Brief    : Records live key notes into a {note, dur} song buffer that has
//            the same format as the auto-play song sheets. The optional LED
//            mirror is enabled by the macro NOTE_REC_LED_EN.
// Revision : 1.0  initial release
// ============================================================================
module note_recorder #(
    parameter int TICK_CYCLES = 10_000_000,
    parameter int DEPTH       = 64,
    parameter int AW          = 6,
    parameter int NOTE_W      = 5,
    parameter int DUR_W       = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              mode,
    input  logic                    start,
    input  logic                    stop,
    input  logic [NOTE_W-1:0]       note_in,
    input  logic [AW-1:0]           rd_addr,
    output logic [NOTE_W+DUR_W-1:0] rd_data,
    output logic [AW:0]             count,
    output logic                    recording,
    output logic                    full,
    output logic [7:0]              led
);

    localparam int                 c_TW         = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [2:0]         c_MODE_REC   = 3'b100;
    localparam logic [DUR_W-1:0]   c_DUR_MAX    = '1;
    localparam logic [c_TW-1:0]    c_TICK_LAST  = c_TW'(TICK_CYCLES - 1);
    localparam logic [AW:0]        c_LAST_COUNT = (AW+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_REC   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                    r_state;
    logic [c_TW-1:0]           r_tick;
    logic [DUR_W-1:0]          r_dur;
    logic [NOTE_W-1:0]         r_cur_note;
    logic [AW:0]               r_count;
    logic                      r_full;
    logic                      r_recording;
    logic [NOTE_W+DUR_W-1:0]   r_rd_data;
    logic [NOTE_W+DUR_W-1:0]   r_mem [DEPTH];

    logic                      w_rec_mode;
    logic                      w_wrap;
    logic [DUR_W-1:0]          w_dur_eff;
    logic                      w_sat;
    logic                      w_close;
    logic                      w_write;
    logic                      w_last;
    logic [DUR_W-1:0]          w_wr_dur;
    logic [NOTE_W+DUR_W-1:0]   w_wr_data;

    // w_dur_eff already counts a tick that completes on this very cycle, so a
    // segment closed exactly on a tick boundary gets its full length.
    assign w_rec_mode = (mode == c_MODE_REC);
    assign w_wrap     = (r_tick == c_TICK_LAST);
    assign w_dur_eff  = r_dur + DUR_W'(w_wrap);
    assign w_sat      = w_wrap && (w_dur_eff == c_DUR_MAX);
    assign w_close    = stop || !w_rec_mode;
    assign w_write    = (r_state == S_REC) && (w_close || (note_in != r_cur_note) || w_sat);
    assign w_last     = (r_count == c_LAST_COUNT);
    assign w_wr_dur   = (w_dur_eff == '0) ? DUR_W'(1) : w_dur_eff;
    assign w_wr_data  = {r_cur_note, w_wr_dur};

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_count[AW-1:0]] <= w_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_tick      <= '0;
            r_dur       <= '0;
            r_cur_note  <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_recording <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start && w_rec_mode) begin
                        r_state     <= S_ARMED;
                        r_count     <= '0;
                        r_full      <= 1'b0;
                        r_recording <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (!w_rec_mode) begin
                        r_state     <= S_IDLE;
                        r_count     <= '0;
                        r_recording <= 1'b0;
                    end else if (stop) begin
                        r_state     <= S_DONE;
                        r_recording <= 1'b0;
                    end else if (note_in != '0) begin
                        r_state    <= S_REC;
                        r_cur_note <= note_in;
                        r_dur      <= '0;
                        r_tick     <= '0;
                    end
                end
                S_REC: begin
                    if (w_write) begin
                        r_count <= r_count + 1'b1;
                        // A full buffer ends the take even if a new note just began.
                        if (w_close || w_last) begin
                            r_state     <= S_DONE;
                            r_recording <= 1'b0;
                            if (w_last) begin
                                r_full <= 1'b1;
                            end
                        end else begin
                            r_cur_note <= note_in;
                            r_dur      <= '0;
                            r_tick     <= '0;
                        end
                    end else begin
                        r_tick <= w_wrap ? '0 : r_tick + c_TW'(1);
                        r_dur  <= w_dur_eff;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_data   = r_rd_data;
    assign count     = r_count;
    assign recording = r_recording;
    assign full      = r_full;

`ifdef NOTE_REC_LED_EN
    logic [NOTE_W-1:0] w_led_idx;

    always_comb begin
        w_led_idx = (r_cur_note - NOTE_W'(1)) % NOTE_W'(7);
        led       = {r_recording, 7'b0};
        if ((r_state == S_REC) && (r_cur_note != '0)) begin
            led[6:0] = 7'(1) << w_led_idx;
        end
    end
`else
    assign led = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_note_recorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_recorder
// Brief    : Self-checking bench for note_recorder: directed takes plus random
//            play against a segment-timing reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_note_recorder;

    localparam int c_TICK  = 4;
    localparam int c_DEPTH = 64;

    logic        clk;
    logic        rst_n;
    logic [2:0]  mode;
    logic        start;
    logic        stop;
    logic [4:0]  note_in;
    logic [5:0]  rd_addr;
    logic [12:0] rd_data;
    logic [6:0]  count;
    logic        recording;
    logic        full;
    logic [7:0]  led;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    note_recorder #(
        .TICK_CYCLES (c_TICK),
        .DEPTH       (c_DEPTH),
        .AW          (6),
        .NOTE_W      (5),
        .DUR_W       (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .start     (start),
        .stop      (stop),
        .note_in   (note_in),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .count     (count),
        .recording (recording),
        .full      (full),
        .led       (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a segment's duration is its length in clock cycles
    // divided by the tick length, minimum 1; a segment reaching 255 ticks is
    // cut and restarted with the same note.
    bit          m_arm, m_rec, m_full;
    int          m_count, m_note, m_start, m_cyc, m_n, m_d;
    logic [12:0] m_mem [c_DEPTH];
    bit          m_valid [c_DEPTH];
    logic [12:0] m_rd;
    bit          m_rd_valid;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_arm = 0; m_rec = 0; m_full = 0; m_count = 0; m_note = 0;
                m_cyc = 0; m_start = 0; m_rd = '0; m_rd_valid = 1;
                for (int i = 0; i < c_DEPTH; i++) m_valid[i] = 0;
            end else begin
                m_rd_valid = m_valid[rd_addr];
                m_rd       = m_mem[rd_addr];
                m_cyc++;
                if (m_rec) begin
                    m_n = m_cyc - m_start;
                    if (stop || mode != 3'b100 || note_in != 5'(m_note) || m_n == 255 * c_TICK) begin
                        m_d = (m_n / c_TICK < 1) ? 1 : m_n / c_TICK;
                        m_mem[m_count]   = {5'(m_note), 8'(m_d)};
                        m_valid[m_count] = 1;
                        m_count++;
                        if (stop || mode != 3'b100 || m_count == c_DEPTH) begin
                            m_rec = 0;
                            if (m_count == c_DEPTH) m_full = 1;
                        end else begin
                            m_note  = note_in;
                            m_start = m_cyc;
                        end
                    end
                end else if (m_arm) begin
                    if (mode != 3'b100) begin
                        m_arm = 0; m_count = 0;
                    end else if (stop) begin
                        m_arm = 0;
                    end else if (note_in != 0) begin
                        m_arm = 0; m_rec = 1; m_note = note_in; m_start = m_cyc;
                    end
                end else if (start && mode == 3'b100) begin
                    m_arm = 1; m_count = 0; m_full = 0;
                end
            end
        end
    end

    function automatic logic [7:0] model_led();
        logic [7:0] v;
        v = 8'h00;
`ifdef NOTE_REC_LED_EN
        v[7] = m_arm || m_rec;
        if (m_rec && m_note != 0) v[(m_note - 1) % 7] = 1'b1;
`endif
        return v;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && cmp_en) begin
                check("count", 32'(count), 32'(m_count));
                check("full", 32'(full), 32'(m_full));
                check("recording", 32'(recording), 32'(m_arm || m_rec));
                check("led", 32'(led), 32'(model_led()));
                if (m_rd_valid) check("rd_data", 32'(rd_data), 32'(m_rd));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic pulse_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; @(negedge clk); stop = 1'b0;
    endtask

    task automatic hold(input logic [4:0] n, input int cycles);
        note_in = n;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic read_check(input string name, input logic [5:0] a, input logic [12:0] exp);
        rd_addr = a;
        @(negedge clk);
        check(name, 32'(rd_data), 32'(exp));
    endtask

    int          hold_left;
    logic [7:0]  led_exp;

    initial begin
        rst_n = 1'b0; mode = 3'b100; start = 1'b0; stop = 1'b0;
        note_in = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        check("reset_count", 32'(count), 32'd0);
        check("reset_full", 32'(full), 32'd0);
        check("reset_recording", 32'(recording), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'd0);
        check("reset_led", 32'(led), 32'd0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // Take with leading silence, a mid-take rest and a trailing note.
        pulse_start();
        hold(5'd0, 10);
        hold(5'd8, 12);
        hold(5'd0, 8);
        hold(5'd12, 1);
`ifdef NOTE_REC_LED_EN
        led_exp = 8'b1001_0000;
`else
        led_exp = 8'h00;
`endif
        check("led_note12", 32'(led), 32'(led_exp));
        hold(5'd12, 3);
        note_in = '0;
        pulse_stop();
        check("t1_count", 32'(count), 32'd3);
        check("t1_recording", 32'(recording), 32'd0);
        read_check("t1_entry0", 6'd0, {5'd8, 8'd3});
        read_check("t1_entry1", 6'd1, {5'd0, 8'd2});
        read_check("t1_entry2", 6'd2, {5'd12, 8'd1});

        // Long note splits at the duration ceiling.
        pulse_start();
        hold(5'd9, 1030);
        pulse_stop();
        check("t2_count", 32'(count), 32'd2);
        read_check("t2_entry0", 6'd0, {5'd9, 8'd255});
        read_check("t2_entry1", 6'd1, {5'd9, 8'd2});

        // Buffer overflow: 70 alternating segments, capture stops at 64.
        pulse_start();
        for (int k = 0; k < 70; k++) hold((k % 2 == 0) ? 5'd10 : 5'd11, 4);
        note_in = '0;
        check("t3_count", 32'(count), 32'd64);
        check("t3_full", 32'(full), 32'd1);
        check("t3_recording", 32'(recording), 32'd0);
        read_check("t3_entry0", 6'd0, {5'd10, 8'd1});
        read_check("t3_entry63", 6'd63, {5'd11, 8'd1});

        // Leaving record mode flushes the running note; start outside mode is ignored.
        pulse_start();
        hold(5'd13, 8);
        mode = 3'b011;
        @(negedge clk);
        pulse_start();
        check("t4_recording", 32'(recording), 32'd0);
        check("t4_count", 32'(count), 32'd1);
        check("t4_full", 32'(full), 32'd0);
        read_check("t4_entry0", 6'd0, {5'd13, 8'd2});
        mode = 3'b100;

        // Asynchronous reset in the middle of a take.
        pulse_start();
        hold(5'd5, 6);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_count", 32'(count), 32'd0);
        check("t5_async_recording", 32'(recording), 32'd0);
        check("t5_async_led", 32'(led), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) hold(5'(k + 1), 2);
        check("t5_no_write_count", 32'(count), 32'd0);
        check("t5_idle_recording", 32'(recording), 32'd0);

        // Random play checked cycle by cycle against the model.
        hold_left = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 59) == 0);
            stop  = ($urandom_range(0, 399) == 0);
            mode  = ($urandom_range(0, 299) == 0) ? 3'($urandom_range(0, 7)) : 3'b100;
            if (hold_left == 0) begin
                note_in   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                hold_left = $urandom_range(1, 14);
            end else begin
                hold_left--;
            end
            rd_addr = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 2499) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        start = 1'b0; stop = 1'b0; mode = 3'b100;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
